// File: rtl/bank_pkg.sv
// Shared sizing for the bank queue controller and the round-robin grant picker.
package bank_pkg;
  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  MAX_CNT  = 3'd7;
  localparam int                N_TELLER = 2;
  localparam int                DEB_CYC  = 4;
  localparam int                PTR_W    = (N_TELLER > 1) ? $clog2(N_TELLER) : 1;

  // First pending teller at or after ptr, wrapping; zero when nothing is pending.
  function automatic logic [N_TELLER-1:0] next_rr(input logic [PTR_W-1:0]    ptr,
                                                  input logic [N_TELLER-1:0] pending);
    logic [N_TELLER-1:0] gnt;
    logic                found;
    int                  idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N_TELLER; k++) begin
      idx = (int'(ptr) + k) % N_TELLER;
      if (!found && pending[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/debounce_edge.sv
// Level debouncer: the output follows the raw input only after DEB_CYC agreeing
// samples in a row; rise_o pulses for one cycle when the debounced level goes high.
module debounce_edge #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int            CW     = $clog2(DEB_CYC);
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Down-counter runs only while the raw input disagrees with the debounced level.
  always_comb begin
    cnt_d   = RELOAD;
    level_d = level_q;
    rise_d  = 1'b0;
    if (raw_i != level_q) begin
      if (cnt_q == '0) begin
        level_d = raw_i;
        rise_d  = raw_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= RELOAD;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/bank_queue_ctrl.sv
// Waiting-line controller: debounced arrivals fill a saturating count, debounced
// teller requests are served round-robin while customers are waiting.
module bank_queue_ctrl
  import bank_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                arrive_in,
  input  logic [N_TELLER-1:0] teller_req,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic [N_TELLER-1:0] grant,
  output logic                reject,
  output logic [7:0]          served_total
);
  logic                arrive_evt;
  logic [N_TELLER-1:0] teller_evt;
  logic [N_TELLER:0]   lvl_unused;

  debounce_edge #(.DEB_CYC(DEB_CYC)) u_deb_arrive (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (arrive_in),
    .level_o(lvl_unused[0]),
    .rise_o (arrive_evt)
  );

  for (genvar i = 0; i < N_TELLER; i++) begin : g_teller
    debounce_edge #(.DEB_CYC(DEB_CYC)) u_deb_teller (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (teller_req[i]),
      .level_o(lvl_unused[i+1]),
      .rise_o (teller_evt[i])
    );
  end

  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic [N_TELLER-1:0] grant_q, grant_d;
  logic [N_TELLER-1:0] pending_q, pending_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                reject_q, reject_d;
  logic [7:0]          served_q, served_d;
  logic                any_grant;

  // Grant uses the pre-update count, so a fresh arrival at zero is served next cycle.
  always_comb begin
    grant_d = '0;
    if (count_q != '0) grant_d = next_rr(ptr_q, pending_q);
    any_grant = |grant_d;

    pending_d = (pending_q | teller_evt) & ~grant_d;

    ptr_d = ptr_q;
    for (int i = 0; i < N_TELLER; i++) begin
      if (grant_d[i]) ptr_d = PTR_W'((i + 1) % N_TELLER);
    end

    count_d  = count_q;
    reject_d = 1'b0;
    case ({arrive_evt, any_grant})
      2'b10: begin
        if (count_q < MAX_CNT) count_d = count_q + 1'b1;
        else                   reject_d = 1'b1;
      end
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d   = (count_d == MAX_CNT);
    empty_d  = (count_d == '0);
    served_d = served_q + {7'd0, any_grant};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      grant_q   <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      reject_q  <= 1'b0;
      served_q  <= '0;
    end else begin
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      reject_q  <= reject_d;
      served_q  <= served_d;
    end
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign grant        = grant_q;
  assign reject       = reject_q;
  assign served_total = served_q;
endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Directed bench for bank_queue_ctrl: debounce latency, glitch rejection,
// saturation, round-robin service, arrival-with-grant and reset behaviour.
module tb_bank_queue_ctrl;
  logic       clk;
  logic       reset;
  logic       arrive_in;
  logic [1:0] teller_req;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [1:0] grant;
  logic       reject;
  logic [7:0] served_total;

  int checks = 0;
  int errors = 0;

  bank_queue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .arrive_in   (arrive_in),
    .teller_req  (teller_req),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .grant       (grant),
    .reject      (reject),
    .served_total(served_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clean arrival: counted at the 5th high edge, level back low after 4 low edges.
  task automatic do_arrival();
    arrive_in = 1'b1;
    tick(5);
    arrive_in = 1'b0;
    tick(4);
  endtask

  initial begin
    reset      = 1'b1;
    arrive_in  = 1'b0;
    teller_req = 2'b00;
    tick(2);
    check("rst_count",  32'(count), 32'd0);
    check("rst_full",   32'(full), 32'd0);
    check("rst_empty",  32'(empty), 32'd1);
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    check("rst_served", 32'(served_total), 32'd0);
    reset = 1'b0;

    // glitchy sensor never reaches four agreeing samples
    arrive_in = 1'b1; tick(3);
    arrive_in = 1'b0; tick(1);
    arrive_in = 1'b1; tick(3);
    arrive_in = 1'b0; tick(6);
    check("glitch_count", 32'(count), 32'd0);
    check("glitch_empty", 32'(empty), 32'd1);

    // clean arrival held for 10 cycles
    arrive_in = 1'b1;
    tick(4);
    check("arr_e4_count", 32'(count), 32'd0);
    check("arr_e4_empty", 32'(empty), 32'd1);
    tick(1);
    check("arr_e5_count", 32'(count), 32'd1);
    check("arr_e5_empty", 32'(empty), 32'd0);
    tick(5);
    check("arr_e10_count", 32'(count), 32'd1);
    arrive_in = 1'b0;
    tick(4);

    // saturation at 7 with a single reject pulse on the 8th arrival
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int i = 0; i < 7; i++) do_arrival();
    check("sat_count", 32'(count), 32'd7);
    check("sat_full",  32'(full), 32'd1);
    arrive_in = 1'b1;
    tick(4);
    check("sat8_pre_reject", 32'(reject), 32'd0);
    tick(1);
    check("sat8_reject", 32'(reject), 32'd1);
    check("sat8_count",  32'(count), 32'd7);
    tick(1);
    check("sat8_reject_end", 32'(reject), 32'd0);
    check("sat8_count_end",  32'(count), 32'd7);
    arrive_in = 1'b0;
    tick(4);

    // both tellers at once from count 3, pointer at 0
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int i = 0; i < 3; i++) do_arrival();
    check("rr_start_count", 32'(count), 32'd3);
    teller_req = 2'b11;
    tick(5);
    check("rr_pend_grant", 32'(grant), 32'd0);
    check("rr_pend_count", 32'(count), 32'd3);
    tick(1);
    check("rr_g1_grant",  32'(grant), 32'b01);
    check("rr_g1_count",  32'(count), 32'd2);
    check("rr_g1_served", 32'(served_total), 32'd1);
    tick(1);
    check("rr_g2_grant",  32'(grant), 32'b10);
    check("rr_g2_count",  32'(count), 32'd1);
    check("rr_g2_served", 32'(served_total), 32'd2);
    tick(1);
    check("rr_idle_grant", 32'(grant), 32'd0);
    check("rr_idle_count", 32'(count), 32'd1);
    teller_req = 2'b00;
    tick(4);

    // full queue: arrival and grant in the same cycle
    for (int i = 0; i < 6; i++) do_arrival();
    check("fg_full_pre", 32'(full), 32'd1);
    teller_req = 2'b11;
    tick(1);
    arrive_in = 1'b1;
    tick(4);
    check("fg_pre_grant", 32'(grant), 32'd0);
    check("fg_pre_count", 32'(count), 32'd7);
    tick(1);
    check("fg_grant",  32'(grant), 32'b01);
    check("fg_count",  32'(count), 32'd7);
    check("fg_reject", 32'(reject), 32'd0);
    check("fg_full",   32'(full), 32'd1);
    check("fg_served", 32'(served_total), 32'd3);
    tick(1);
    check("fg2_grant",  32'(grant), 32'b10);
    check("fg2_count",  32'(count), 32'd6);
    check("fg2_full",   32'(full), 32'd0);
    check("fg2_served", 32'(served_total), 32'd4);
    teller_req = 2'b00;
    arrive_in  = 1'b0;
    tick(5);

    // teller 1 waits on an empty queue, then is served after an arrival
    reset = 1'b1; tick(1); reset = 1'b0;
    teller_req = 2'b10;
    tick(5);
    check("e0_grant", 32'(grant), 32'd0);
    check("e0_empty", 32'(empty), 32'd1);
    tick(3);
    check("e0_hold_grant", 32'(grant), 32'd0);
    check("e0_hold_count", 32'(count), 32'd0);
    arrive_in = 1'b1;
    tick(4);
    check("e0_arr_e4_count", 32'(count), 32'd0);
    tick(1);
    check("e0_arr_count", 32'(count), 32'd1);
    check("e0_arr_grant", 32'(grant), 32'd0);
    check("e0_arr_empty", 32'(empty), 32'd0);
    tick(1);
    check("e0_srv_grant",  32'(grant), 32'b10);
    check("e0_srv_count",  32'(count), 32'd0);
    check("e0_srv_empty",  32'(empty), 32'd1);
    check("e0_srv_served", 32'(served_total), 32'd1);
    tick(1);
    check("e0_after_grant", 32'(grant), 32'd0);
    arrive_in  = 1'b0;
    teller_req = 2'b00;
    tick(4);

    // reset mid-debounce drops the pending teller 0 request
    teller_req = 2'b01;
    tick(5);
    check("mr_pend_grant", 32'(grant), 32'd0);
    arrive_in = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("mr_count",  32'(count), 32'd0);
    check("mr_full",   32'(full), 32'd0);
    check("mr_empty",  32'(empty), 32'd1);
    check("mr_grant",  32'(grant), 32'd0);
    check("mr_reject", 32'(reject), 32'd0);
    check("mr_served", 32'(served_total), 32'd0);
    teller_req = 2'b00;
    reset      = 1'b0;
    tick(4);
    check("mr_held_e4_count", 32'(count), 32'd0);
    tick(1);
    check("mr_held_e5_count", 32'(count), 32'd1);
    check("mr_held_e5_empty", 32'(empty), 32'd0);
    tick(1);
    check("mr_lost_grant", 32'(grant), 32'd0);
    check("mr_lost_count", 32'(count), 32'd1);
    arrive_in = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
